serial_addsub_engine: RTL and testbench

Bit-serial, multi-bit add/subtract engine. It accepts two WIDTH-bit operands and a mode bit through a valid/ready handshake and processes them LSB-first, one bit per clock, through a single 1-bit add/sub cell. It returns the WIDTH-bit result plus carry/borrow and signed-overflow flags through a second valid/ready handshake. It is the sequential, word-level counterpart of the team's 1-bit add/sub slice and sits between an operand source and a result consumer.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_bit_cell.sv | 17 +
 rtl/serial_addsub_engine.sv | 138 +++++++++++++
 tb/tb_serial_addsub_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit add/subtract cell: B is conditionally inverted by m, carry-out is the majority.
module addsub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic m,
    output logic sum,
    output logic cout
);

    logic bx;

    assign bx   = b ^ m;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/serial_addsub_engine.sv
// Bit-serial WIDTH-bit add/subtract engine, LSB first, with valid/ready handshakes on both sides.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub_engine
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             accept, last;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             m_q, c_q;
    logic             sum, cout;
    logic [WIDTH-1:0] r_fin, r_out;
    logic             ovf;

`ifdef ADDSUB_SAT_EN
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic a_msb_q;

    function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] r,
                                                input logic ov,
                                                input logic a_msb);
        logic signed [WIDTH-1:0] s;
        s = a_msb ? SMIN : SMAX;
        return ov ? s : r;
    endfunction
`endif

    addsub_bit_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .m    (m_q),
        .sum  (sum),
        .cout (cout)
    );

    // Final word: the last sum bit lands in the MSB; carry into the MSB is still in c_q.
    assign r_fin = {sum, r_sh[WIDTH-1:1]};
    assign ovf   = c_q ^ cout;

`ifdef ADDSUB_SAT_EN
    assign r_out = sat_fn(r_fin, ovf, a_msb_q);
`else
    assign r_out = r_fin;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and output registers; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            carry_borrow <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_ready <= (state_nxt == IDLE);
            res_valid   <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);
            if (last) begin
                result       <= r_out;
                overflow     <= ovf;
                carry_borrow <= cout ^ (m_q == MODE_SUB);
            end
        end
    end

    // Serial datapath; fully reloaded on every accept, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a_in;
            b_sh <= b_in;
            m_q  <= mode;
            c_q  <= mode;
            cnt  <= '0;
`ifdef ADDSUB_SAT_EN
            a_msb_q <= a_in[WIDTH-1];
`endif
        end else if (state == RUN) begin
            r_sh <= r_fin;
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c_q  <= cout;
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Directed scoreboard bench for serial_addsub_engine at WIDTH=8.
module tb_serial_addsub_engine;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         start_ready, res_valid, carry_borrow, overflow, busy;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cb;
        logic         ov;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    serial_addsub_engine #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .mode         (mode),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .result       (result),
        .carry_borrow (carry_borrow),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        logic [W:0] s;
        exp_t e;
        if (!m) begin
            s    = {1'b0, a} + {1'b0, b};
            e.cb = s[W];
            e.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s    = {1'b0, a} - {1'b0, b};
            e.cb = (a < b);
            e.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        e.r = s[W-1:0];
`ifdef ADDSUB_SAT_EN
        if (e.ov) e.r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_carry_borrow"}, 32'(carry_borrow), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Drive one operand word at a falling edge; returns #1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready_wait", 32'(start_ready), 32'd1);
        a_in        = a;
        b_in        = b;
        mode        = m;
        start_valid = 1'b1;
        sbq.push_back(model(a, b, m));
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Wait for the result, check latency and scoreboard entry; leaves the engine in DONE.
    task automatic collect(input string tag, output exp_t e);
        int lat;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        if (sbq.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(sbq.size()), 32'd1);
            e = '0;
        end else begin
            e = sbq.pop_front();
        end
        chk({tag, "_result"}, 32'(result), 32'(e.r));
        chk({tag, "_carry_borrow"}, 32'(carry_borrow), 32'(e.cb));
        chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
        chk({tag, "_start_ready_done"}, 32'(start_ready), 32'd0);
    endtask

    task automatic handshake(input string tag, input exp_t e);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, "_res_valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
        chk({tag, "_result_held"}, 32'(result), 32'(e.r));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m);
        exp_t e;
        send(a, b, m);
        collect(tag, e);
        handshake(tag, e);
    endtask

    initial begin
        exp_t e;

        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        run_op("add_05_03", 8'h05, 8'h03, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Backpressure in DONE with a stray start pulse
        send(8'h7F, 8'h01, 1'b0);
        collect("bp", e);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a_in        = 8'h11;
                b_in        = 8'h22;
                start_valid = 1'b1;
            end
            @(posedge clk);
            #1 start_valid = 1'b0;
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_start_ready", 32'(start_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_result", 32'(result), 32'(e.r));
            chk("bp_carry_borrow", 32'(carry_borrow), 32'(e.cb));
            chk("bp_overflow", 32'(overflow), 32'(e.ov));
        end
        handshake("bp", e);
        repeat (12) @(posedge clk);
        #1 chk("bp_pulse_ignored", 32'(res_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of RUN
        send(8'h12, 8'h34, 1'b0);
        void'(sbq.pop_back());
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrun_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_ready", 32'(start_ready), 32'd1);
        chk("post_reset_valid", 32'(res_valid), 32'd0);
        run_op("add_01_01", 8'h01, 8'h01, 1'b0);
        chk("add_01_01_value", 32'(result), 32'h02);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
